// File: rtl/potential_mem.sv
// Neuron membrane-potential store: one read port (latency 1, write-first forwarding),
// one write port, and a V_REST init sweep that runs after reset or on request.
module potential_mem #(
    parameter int          NUM_NEURONS = 256,
    parameter int          ADDR_W      = 8,
    parameter logic [31:0] V_REST      = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_data_valid,
    output logic [31:0]       rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              init_req,
    output logic              init_busy,
    output logic              addr_err
);
    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(NUM_NEURONS);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_NEURONS - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic [31:0]       mem [NUM_NEURONS];

    logic              rd_acc, rd_in, wr_in, wr_go;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [31:0]       mem_wd, rd_val;

    assign init_busy = (state == INIT);
    assign rd_ready  = (state == RUN);
    assign rd_acc    = rd_valid && rd_ready;
    assign rd_in     = {1'b0, rd_addr} < LIMIT;
    assign wr_in     = {1'b0, wr_addr} < LIMIT;
    assign wr_go     = (state == RUN) && wr_en && wr_in;

    // The sweep owns the write port while INIT; nothing touches the array during reset.
    always_comb begin
        mem_we = RESET_N && (init_busy || wr_go);
        mem_wa = init_busy ? init_cnt : wr_addr;
        mem_wd = init_busy ? V_REST : wr_data;
    end

    always_comb begin
        rd_val = V_REST;
        if (rd_in) begin
            if (wr_go && (wr_addr == rd_addr))
                rd_val = wr_data;
            else
                rd_val = mem[rd_addr];
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state         <= INIT;
            init_cnt      <= '0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
            addr_err      <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt      <= init_cnt + 1'b1;
                    rd_data_valid <= 1'b0;
                    addr_err      <= 1'b0;
                    if (init_cnt == LAST)
                        state <= RUN;
                end
                default: begin
                    rd_data_valid <= rd_acc;
                    if (rd_acc)
                        rd_data <= rd_val;
                    // A simultaneous bad read and bad write still give a single pulse.
                    addr_err <= (rd_acc && !rd_in) || (wr_en && !wr_in);
                    if (init_req) begin
                        state    <= INIT;
                        init_cnt <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/potential_mem.md
POTENTIAL_MEM -- requirements
Module: potential_mem

Interface
REQ-001 The block SHALL have parameter NUM_NEURONS, default 256: number of neuron potential entries.
REQ-002 The block SHALL have parameter ADDR_W, default 8: neuron address width; NUM_NEURONS <= 2**ADDR_W.
REQ-003 The block SHALL have parameter V_REST, default 32'h0000_0000: rest potential loaded by the init sweep.
REQ-004 The block SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RESET_N  input  1  reset, synchronous and active-low.
REQ-006 The block SHALL have port rd_valid  input  1  read request present.
REQ-007 The block SHALL have port rd_addr  input  ADDR_W  neuron index to read.
REQ-008 The block SHALL have port rd_ready  output  1  block can accept a read this cycle.
REQ-009 The block SHALL have port rd_data_valid  output  1  rd_data holds a completed read.
REQ-010 The block SHALL have port rd_data  output  32  potential read out, supplied to the integrator adder.
REQ-011 The block SHALL have port wr_en  input  1  write strobe from the spike/reset stage.
REQ-012 The block SHALL have port wr_addr  input  ADDR_W  neuron index to write.
REQ-013 The block SHALL have port wr_data  input  32  post-reset potential to store.
REQ-014 The block SHALL have port init_req  input  1  request to reload every entry with V_REST.
REQ-015 The block SHALL have port init_busy  output  1  init sweep in progress.
REQ-016 The block SHALL have port addr_err  output  1  one-cycle pulse on an out-of-range accepted access.

Function
REQ-017 The block SHALL have exactly two states, INIT and RUN.
REQ-018 In INIT, the block SHALL write V_REST to entry init_cnt each cycle, with init_cnt counting 0..NUM_NEURONS-1, and SHALL go to RUN after it writes entry NUM_NEURONS-1 (sweep lasts NUM_NEURONS cycles).
REQ-019 init_busy SHALL be 1 exactly while in INIT; rd_ready SHALL equal !init_busy.
REQ-020 In INIT, the block SHALL ignore wr_en, init_req and rd_valid, and SHALL leave memory untouched except by the sweep.
REQ-021 In RUN, an init_req=1 sample SHALL clear init_cnt to 0 and enter INIT on the next cycle.
REQ-022 A read SHALL be accepted at edge t when rd_valid && rd_ready are both 1.
REQ-023 For a read accepted at edge t, rd_data_valid SHALL be 1 and rd_data SHALL be valid during the cycle after t, for exactly one cycle (latency 1).
REQ-024 rd_data_valid SHALL be 0 in every cycle that has no accepted read at the preceding edge.
REQ-025 rd_data SHALL hold its last value while rd_data_valid=0.
REQ-026 The block SHALL allow back-to-back reads: one accepted per cycle, no bubbles.
REQ-027 In RUN, a write with wr_en=1 and wr_addr < NUM_NEURONS SHALL update the entry at the edge.
REQ-028 A read and a write to the same address at the same edge SHALL return wr_data (write-first forwarding).
REQ-029 A read to a different address at the same edge as a write SHALL return the stored value.
REQ-030 A write at edge t SHALL be visible to any read accepted at edge t+1 or later.
REQ-031 An accepted read with rd_addr >= NUM_NEURONS SHALL return V_REST and SHALL raise addr_err for the one cycle in which rd_data_valid=1.
REQ-032 A write in RUN with wr_addr >= NUM_NEURONS SHALL be discarded and SHALL raise addr_err for the next cycle.
REQ-033 If REQ-031 and REQ-032 occur at the same edge, the block SHALL raise addr_err for a single cycle.
REQ-034 rd_data SHALL be exactly the 32-bit stored value, with no arithmetic and no sign handling.
REQ-035 init_req=1 together with rd_valid or wr_en in RUN: the read and the write at that same edge SHALL complete normally, and INIT SHALL start at the next cycle.

Reset
REQ-036 RESET_N=0 sampled at an edge SHALL set state=INIT, init_cnt=0, init_busy=1, rd_ready=0, rd_data_valid=0, rd_data=0, addr_err=0.
REQ-037 Reset during INIT or RUN SHALL abort the current operation, drop any in-flight read (no rd_data_valid afterward), and restart the full sweep.
REQ-038 The sweep SHALL begin on the first edge with RESET_N=1.

Verification
REQ-039 The bench SHALL cover: release reset, NUM_NEURONS=256 -> init_busy=1 for 256 cycles, then rd_ready=1; a read of addr 17 returns 0.
REQ-040 The bench SHALL cover: write 0x0000_0064 to addr 5; read addr 5 on the next cycle -> rd_data=0x64 one cycle after acceptance.
REQ-041 The bench SHALL cover: write 0x1234 to addr 9 and read addr 9 at the same edge -> rd_data=0x1234; a read of addr 10 at the same edge -> old value.
REQ-042 The bench SHALL cover: reads of addrs 0..3 on consecutive cycles -> rd_data_valid high 4 consecutive cycles, data in order.
REQ-043 The bench SHALL cover: NUM_NEURONS=200, read addr 250 -> rd_data=V_REST, addr_err for 1 cycle; write addr 210 -> discarded, addr_err pulse.
REQ-044 The bench SHALL cover: write 0x50 to addr 3, init_req, RESET_N low mid-sweep -> sweep restarts from 0; after completion, addr 3 reads V_REST.
